// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4:1 mux round-robin arbiter.
// Contents: requester count, select width, FSM state encoding,
// last-owner reset value and a one-hot decode helper.
package mux4_arb_defs;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned SEL_W   = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Pointer value out of reset, so the first search starts at requester 0
   localparam logic [SEL_W-1:0] LAST_RST = 2'd3;

   // Index -> one-hot grant vector
   function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      return NUM_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker for four requesters (combinational).
// Ports:
//   req     : request vector
//   last    : index of the previous winner; the scan starts at last+1
//   mask_en : drop bit 'last' from the scan when another request is present
//   pick    : index of the winning requester (valid when any=1)
//   any     : at least one eligible request
module rr_pick4
   import mux4_arb_defs::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   last,
   input  logic               mask_en,
   output logic [SEL_W-1:0]   pick,
   output logic               any
);

   logic [NUM_REQ-1:0] req_m;
   logic [NUM_REQ-1:0] req_oth;
   logic [SEL_W-1:0]   idx;

   assign req_oth = req & ~onehot(last);

   // Scan last+1, last+2, ... with wrap; the first set bit wins
   always_comb begin
      req_m = req;
      pick  = last;
      any   = 1'b0;
      idx   = '0;
      if (mask_en && (req_oth != '0)) begin
         req_m = req_oth;
      end
      for (int k = 1; k <= int'(NUM_REQ); k++) begin
         idx = SEL_W'(int'(last) + k);
         if (!any && req_m[idx]) begin
            pick = idx;
            any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing the 4:1 conditional-data mux output.
// {sela,selc} selects the mux input; gnt is the one-hot grant back to the
// requesters. A tenure ends when the owner drops its request or after
// MAX_HOLD accepted transfers (MAX_HOLD=0 means unlimited).
// Optional: define MUX4_ARB_LOCK_EN to add the 'lock' input, which
// suppresses the hold-limit release while high.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   req[3:0]    : requests, bit i = requester of di
//   out_ready   : downstream accepts the mux output this cycle
//   lock        : (MUX4_ARB_LOCK_EN only) keep the current tenure
//   gnt[3:0]    : registered one-hot grant
//   gnt_valid   : registered, equals |gnt
//   sela, selc  : registered mux selects
//   xfer        : combinational, a transfer is accepted this cycle
module mux4_rr_arbiter
   import mux4_arb_defs::*;
#(
   parameter int unsigned MAX_HOLD = 4,
   parameter int unsigned CNT_W    = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               out_ready,
`ifdef MUX4_ARB_LOCK_EN
   input  logic               lock,
`endif
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_valid,
   output logic               sela,
   output logic               selc,
   output logic               xfer
);

   localparam logic [CNT_W-1:0] HOLD_LAST =
      (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

   state_t             state;
   logic [SEL_W-1:0]   last;
   logic [CNT_W-1:0]   hold_cnt;
   logic [SEL_W-1:0]   owner;
   logic               lock_act;
   logic               at_limit;
   logic               hold_rel;
   logic               owner_rel;
   logic [SEL_W-1:0]   pick_last;
   logic [SEL_W-1:0]   pick;
   logic               any;

`ifdef MUX4_ARB_LOCK_EN
   assign lock_act = lock;
`else
   assign lock_act = 1'b0;
`endif

   // Selects always carry the owner's index while in GRANT
   assign owner     = {sela, selc};
   assign xfer      = gnt_valid & out_ready & req[owner];
   assign at_limit  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
   assign hold_rel  = at_limit & xfer & ~lock_act;
   assign owner_rel = (state == GRANT) & (~req[owner] | hold_rel);

   // On release the owner becomes the new pointer, so search from it directly
   assign pick_last = (state == GRANT) ? owner : last;

   rr_pick4 u_pick (
      .req     (req),
      .last    (pick_last),
      .mask_en (hold_rel),
      .pick    (pick),
      .any     (any)
   );

   // State, pointer, hold counter and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last      <= LAST_RST;
         hold_cnt  <= '0;
         gnt       <= '0;
         gnt_valid <= 1'b0;
         sela      <= 1'b0;
         selc      <= 1'b0;
      end else if (state == IDLE) begin
         if (any) begin
            state        <= GRANT;
            gnt          <= onehot(pick);
            gnt_valid    <= 1'b1;
            {sela, selc} <= pick;
            hold_cnt     <= '0;
         end
      end else begin
         if (owner_rel) begin
            last <= owner;
            if (any) begin
               gnt          <= onehot(pick);
               {sela, selc} <= pick;
               hold_cnt     <= '0;
            end else begin
               state     <= IDLE;
               gnt       <= '0;
               gnt_valid <= 1'b0;
            end
         end else if (xfer && !(lock_act && at_limit)) begin
            // Saturates at the limit while locked
            hold_cnt <= hold_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       out_ready;
`ifdef MUX4_ARB_LOCK_EN
   logic       lock;
`endif
   logic [3:0] gnt;
   logic       gnt_valid;
   logic       sela;
   logic       selc;
   logic       xfer;

   int checks = 0;
   int errors = 0;

   mux4_rr_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .out_ready (out_ready),
`ifdef MUX4_ARB_LOCK_EN
      .lock      (lock),
`endif
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .sela      (sela),
      .selc      (selc),
      .xfer      (xfer)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One vector = inputs applied before an edge, outputs expected just after it
   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       rdy;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       valid;
      logic       xfer;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic r, input logic [3:0] q, input logic rd,
                               input logic [3:0] g, input logic [1:0] s,
                               input logic v, input logic x);
      vec_t e;
      e.rst = r; e.req = q; e.rdy = rd;
      e.gnt = g; e.sel = s; e.valid = v; e.xfer = x;
      tbl.push_back(e);
   endfunction

   // Vector with an active grant on requester o
   function automatic void add_own(input logic [3:0] q, input logic rd,
                                   input int o, input logic x);
      logic [3:0] g;
      g = 4'd1 << o;
      add(1'b0, q, rd, g, 2'(o), 1'b1, x);
   endfunction

   task automatic check1(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] q, input logic rd);
      @(negedge clk);
      rst = r; req = q; out_ready = rd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
`ifdef MUX4_ARB_LOCK_EN
      lock = 1'b0;
`endif

      // Reset held two cycles with all requests up
      add(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
      add(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
      // Fairness: d0,d1,d2,d3,d0 each for four transfers, no gaps
      for (int o = 0; o < 5; o++)
         for (int r = 0; r < 4; r++) add_own(4'b1111, 1'b1, o % 4, 1'b1);
      for (int r = 0; r < 4; r++) add_own(4'b1111, 1'b1, 1, 1'b1);
      // d2 granted, two transfers, then d2 drops: d3 next
      for (int r = 0; r < 3; r++) add_own(4'b1111, 1'b1, 2, 1'b1);
      for (int r = 0; r < 4; r++) add_own(4'b1011, 1'b1, 3, 1'b1);
      add_own(4'b1011, 1'b1, 0, 1'b1);
      // Back to full requests until d1 owns the mux
      for (int r = 0; r < 3; r++) add_own(4'b1111, 1'b1, 0, 1'b1);
      add_own(4'b1111, 1'b1, 1, 1'b1);
      // Stall: ten cycles with out_ready low keep d1, count frozen
      for (int r = 0; r < 10; r++) add_own(4'b1111, 1'b0, 1, 1'b0);
      for (int r = 0; r < 3; r++) add_own(4'b1111, 1'b1, 1, 1'b1);
      add_own(4'b1111, 1'b1, 2, 1'b1);
      // Single requester d2 is re-granted back-to-back
      for (int r = 0; r < 10; r++) add_own(4'b0100, 1'b1, 2, 1'b1);
      // Requests vanish: idle, selects keep 10
      add(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
      add(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
      // d3 tenure interrupted by reset, then restart from d0
      add_own(4'b1000, 1'b1, 3, 1'b1);
      add_own(4'b1111, 1'b1, 3, 1'b1);
      add(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
      add_own(4'b1111, 1'b1, 0, 1'b1);

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].req, tbl[i].rdy);
         check1($sformatf("v%0d gnt", i), int'(gnt), int'(tbl[i].gnt));
         check1($sformatf("v%0d sel", i), int'({sela, selc}), int'(tbl[i].sel));
         check1($sformatf("v%0d gnt_valid", i), int'(gnt_valid), int'(tbl[i].valid));
         check1($sformatf("v%0d xfer", i), int'(xfer), int'(tbl[i].xfer));
      end

      // Drop d0 to go idle, then d1 alone: granted exactly one edge later
      drive(1'b0, 4'b0000, 1'b1);
      check1("idle_gnt", int'(gnt), 0);
      n = 0;
      drive(1'b0, 4'b0010, 1'b1);
      n++;
      while (!gnt_valid && n < 5) begin
         drive(1'b0, 4'b0010, 1'b1);
         n++;
      end
      check1("req_to_gnt_latency", n, 1);
      check1("late_gnt", int'(gnt), 4'b0010);
      check1("late_sel", int'({sela, selc}), 1);

`ifdef MUX4_ARB_LOCK_EN
      // Locked d0 keeps the mux past the hold limit until it drops
      drive(1'b1, 4'b1111, 1'b1);
      lock = 1'b1;
      for (int r = 0; r < 10; r++) begin
         drive(1'b0, 4'b1111, 1'b1);
         check1($sformatf("lock_hold%0d", r), int'(gnt), 4'b0001);
      end
      drive(1'b0, 4'b1110, 1'b1);
      check1("lock_release", int'(gnt), 4'b0010);
      lock = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
